// File: rtl/mcycle_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Holds state, operation and ALU control encodings, the iteration count
// and the {hi,lo} accumulator layout.
package mcycle_seq_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mcop_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01
    } alu_ctl_e;

    // Double-width shift register: hi is the upper word, lo the lower word.
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } acc_t;

endpackage

// File: rtl/mcycle_seq_fsm.sv
// Sequencer control: IDLE/COMPUTE/DONE state plus the 5-bit iteration count.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - operation request, honoured only in IDLE
//   state       - current state (registered)
//   busy, done  - registered status flags (COMPUTE / DONE)
//   accept_c    - start accepted this cycle (combinational)
//   last_c      - final iteration this cycle (combinational)
module mcycle_seq_fsm
    import mcycle_seq_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    output state_e state,
    output logic   busy,
    output logic   done,
    output logic   accept_c,
    output logic   last_c
);

    state_e           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // State, counter and status flags; flags follow the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            busy  <= (state_nxt == ST_COMPUTE);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // Next-state logic; the counter wraps 31->0 on the final iteration.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    count_nxt = '0;
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                count_nxt = CNT_W'(count + CNT_W'(1));
                if (count == CNT_W'(ITERS - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle unsigned multiply / divide using one shared external ALU op
// per iteration (shift-add multiply, restoring-style divide).
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   Start, MCycleOp       - request and op select (0 mul, 1 div)
//   Operand1, Operand2    - multiplicand/dividend, multiplier/divisor
//   Result1, Result2      - low word/quotient, high word/remainder
//   Busy, Done            - iterating flag, one-cycle completion pulse
//   ALU_SrcA/SrcB/Control - operands and op code to the shared ALU
//   ALU_isADC, ALU_CFlag  - tied low
//   ALU_Result, ALU_Flags - combinational ALU response, flags {N,Z,C,V}
module mcycle_seq
    import mcycle_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_SrcA,
    output logic [WIDTH-1:0] ALU_SrcB,
    output logic [1:0]       ALU_Control,
    output logic             ALU_isADC,
    output logic             ALU_CFlag,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [3:0]       ALU_Flags
);

    state_e           state;
    logic             accept_c;
    logic             last_c;
    mcop_e            op;
    logic [XLEN-1:0]  d;
    acc_t             acc;
    acc_t             acc_nxt;
    logic             c_flag;
    logic             unused_flags;

    assign c_flag       = ALU_Flags[1];
    assign unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};
    assign ALU_isADC    = 1'b0;
    assign ALU_CFlag    = 1'b0;

    mcycle_seq_fsm u_fsm (
        .clk      (CLK),
        .reset    (RESET),
        .start    (Start),
        .state    (state),
        .busy     (Busy),
        .done     (Done),
        .accept_c (accept_c),
        .last_c   (last_c)
    );

    // One iteration: drive the ALU and form the next {hi,lo}.
    always_comb begin
        ALU_SrcA    = '0;
        ALU_SrcB    = '0;
        ALU_Control = ALU_ADD;
        acc_nxt     = acc;
        if (state == ST_COMPUTE) begin
            ALU_SrcB = d;
            if (op == OP_MUL) begin
                ALU_SrcA    = acc.hi;
                ALU_Control = ALU_ADD;
                if (acc.lo[0]) begin
                    acc_nxt = {c_flag, ALU_Result, acc.lo[XLEN-1:1]};
                end else begin
                    acc_nxt = {1'b0, acc.hi, acc.lo[XLEN-1:1]};
                end
            end else begin
                ALU_SrcA    = {acc.hi[XLEN-2:0], acc.lo[XLEN-1]};
                ALU_Control = ALU_SUB;
                // A set hi[31] means the shifted remainder overflowed 32 bits,
                // so it certainly exceeds the divisor even without a carry.
                if (acc.hi[XLEN-1] || c_flag) begin
                    acc_nxt.hi = ALU_Result;
                    acc_nxt.lo = {acc.lo[XLEN-2:0], 1'b1};
                end else begin
                    acc_nxt.hi = {acc.hi[XLEN-2:0], acc.lo[XLEN-1]};
                    acc_nxt.lo = {acc.lo[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Datapath registers; results load on the final iteration and hold.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op      <= OP_MUL;
            d       <= '0;
            acc     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            acc <= acc_nxt;
            if (accept_c) begin
                op     <= mcop_e'(MCycleOp);
                acc.hi <= '0;
                // Divide keeps the dividend in lo so it shifts out into hi;
                // the divisor is the constant ALU operand.
                if (MCycleOp == OP_DIV) begin
                    d      <= Operand2;
                    acc.lo <= Operand1;
                end else begin
                    d      <= Operand1;
                    acc.lo <= Operand2;
                end
            end
            if (last_c) begin
                Result1 <= acc_nxt.lo;
                Result2 <= acc_nxt.hi;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_seq.sv
// Self-checking bench for mcycle_seq: directed corner cases plus random
// multiply/divide operations checked against an arithmetic reference model.
module tb_mcycle_seq;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic        MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;
    logic [31:0] ALU_SrcA;
    logic [31:0] ALU_SrcB;
    logic [1:0]  ALU_Control;
    logic        ALU_isADC;
    logic        ALU_CFlag;
    logic [31:0] ALU_Result;
    logic [3:0]  ALU_Flags;

    int n_checks = 0;
    int n_errors = 0;

    mcycle_seq #(.WIDTH(32)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Start       (Start),
        .MCycleOp    (MCycleOp),
        .Operand1    (Operand1),
        .Operand2    (Operand2),
        .Result1     (Result1),
        .Result2     (Result2),
        .Busy        (Busy),
        .Done        (Done),
        .ALU_SrcA    (ALU_SrcA),
        .ALU_SrcB    (ALU_SrcB),
        .ALU_Control (ALU_Control),
        .ALU_isADC   (ALU_isADC),
        .ALU_CFlag   (ALU_CFlag),
        .ALU_Result  (ALU_Result),
        .ALU_Flags   (ALU_Flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared ALU model (ARM-style: carry = no borrow on subtract).
    always_comb begin
        logic [32:0] sum;
        sum = '0;
        ALU_Flags = 4'h0;
        case (ALU_Control)
            2'b00: sum = {1'b0, ALU_SrcA} + {1'b0, ALU_SrcB};
            2'b01: sum = {1'b0, ALU_SrcA} + {1'b0, ~ALU_SrcB} + 33'd1;
            default: sum = '0;
        endcase
        ALU_Result   = sum[31:0];
        ALU_Flags[3] = sum[31];
        ALU_Flags[2] = (sum[31:0] == 32'h0);
        ALU_Flags[1] = sum[32];
        if (ALU_Control == 2'b00)
            ALU_Flags[0] = (ALU_SrcA[31] == ALU_SrcB[31]) && (sum[31] != ALU_SrcA[31]);
        else
            ALU_Flags[0] = (ALU_SrcA[31] != ALU_SrcB[31]) && (sum[31] != ALU_SrcA[31]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result as {Result2, Result1}.
    function automatic logic [63:0] ref_model(input logic op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (!op) return 64'(a) * 64'(b);
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Run one operation; optionally pulse Start with other operands at busy cycle poke_at.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at);
        logic [63:0] exp;
        logic [31:0] r1, r2;
        int done_cyc, n_done, busy_bad, alu_bad;
        exp = ref_model(op, a, b);
        done_cyc = -1; n_done = 0; busy_bad = 0; alu_bad = 0;
        r1 = '0; r2 = '0;
        @(negedge CLK);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge CLK); #1;
            if (Done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; r1 = Result1; r2 = Result2;
                end
            end
            if (Busy !== ((cyc >= 1) && (cyc <= 32))) busy_bad++;
            if (!Busy && (ALU_SrcA !== 32'h0 || ALU_SrcB !== 32'h0 || ALU_Control !== 2'b00))
                alu_bad++;
            if (cyc == 1) begin
                Start = 1'b0; MCycleOp = 1'($urandom); Operand1 = $urandom; Operand2 = $urandom;
            end
            if (cyc == poke_at) begin
                Start = 1'b1; MCycleOp = ~op; Operand1 = $urandom; Operand2 = $urandom;
            end
            if (cyc == poke_at + 1) Start = 1'b0;
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'd33);
        check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
        check({tag, "_alu_idle"}, 64'(alu_bad), 64'd0);
        check({tag, "_result1"}, 64'(r1), 64'(exp[31:0]));
        check({tag, "_result2"}, 64'(r2), 64'(exp[63:32]));
        check({tag, "_hold"}, {Result2, Result1}, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        op;
        int          n_done;
        RESET = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_results", {Result2, Result1}, 64'h0);
        check("rst_alu", {30'h0, ALU_SrcA, ALU_Control}, 64'h0);
        check("rst_srcb", 64'(ALU_SrcB), 64'h0);
        check("tie_offs", {62'h0, ALU_isADC, ALU_CFlag}, 64'h0);

        // Reset wins over a simultaneous Start.
        Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd4;
        @(posedge CLK); #1;
        Start = 1'b0; RESET = 1'b0;
        check("rst_prio_busy", 64'(Busy), 64'd0);
        @(posedge CLK); #1;
        check("rst_prio_busy2", 64'(Busy), 64'd0);

        run_op("mul_7x6", 1'b0, 32'd7, 32'd6, -1);
        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);
        run_op("div_tflag", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1);
        run_op("div_zero", 1'b1, 32'h1234_5678, 32'h0, -1);
        run_op("start_ignored", 1'b0, 32'h0001_2345, 32'h0000_BEEF, 5);

        // Reset in the middle of an operation.
        @(negedge CLK);
        Start = 1'b1; MCycleOp = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd9;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge CLK); #1;
            if (cyc == 1) Start = 1'b0;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_results", {Result2, Result1}, 64'h0);
        n_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge CLK); #1;
            if (Done || Busy) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        run_op("after_rst", 1'b1, 32'd1000, 32'd9, -1);

        // Random operations.
        for (int i = 0; i < 20; i++) begin
            op = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), op, a, b, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
